// File: rtl/gatebach_sieve_pkg.sv
// Shared types and width helpers for the GateBach segmented sieve engine.
package gatebach_sieve_pkg;

   localparam int unsigned DEF_N_PRIMES  = 64;
   localparam int unsigned DEF_WORD_W    = 32;
   localparam int unsigned DEF_SEG_WORDS = 16;
   localparam int unsigned DEF_ADDR_W    = 64;
   localparam int unsigned DEF_P_W       = 32;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_DIV,
      S_MARK,
      S_OUT,
      S_DONE
   } state_t;

   typedef logic [DEF_WORD_W-1:0] word_t;

   // Index width for n entries, never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/gatebach_mod_div.sv
// Restoring remainder unit: one dividend bit per cycle, done pulses ADDR_W cycles after go.
module gatebach_mod_div
   import gatebach_sieve_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned P_W    = DEF_P_W
) (
   input  logic              clk,
   input  logic              i_rst_n,
   input  logic              i_go,
   input  logic [ADDR_W-1:0] i_dividend,
   input  logic [P_W-1:0]    i_divisor,
   output logic              o_done,
   output logic [P_W-1:0]    o_rem
);

   localparam int unsigned CNT_W = idx_w(ADDR_W + 1);

   logic [ADDR_W-1:0] r_dvd;
   logic [P_W-1:0]    r_dvs;
   logic [P_W-1:0]    r_rem;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_run;
   logic              r_done;
   logic [P_W:0]      w_shift;
   logic [P_W:0]      w_trial;

   // Partial remainder shifted by the next dividend bit, and its trial subtraction.
   always_comb begin
      w_shift = {r_rem, r_dvd[ADDR_W-1]};
      w_trial = w_shift - {1'b0, r_dvs};
   end

   // Iteration register: restore when the trial subtraction would go negative.
   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         r_dvd  <= '0;
         r_dvs  <= '0;
         r_rem  <= '0;
         r_cnt  <= '0;
         r_run  <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_go) begin
            r_dvd <= i_dividend;
            r_dvs <= i_divisor;
            r_rem <= '0;
            r_cnt <= CNT_W'(ADDR_W);
            r_run <= 1'b1;
         end else if (r_run) begin
            r_rem <= (w_shift >= {1'b0, r_dvs}) ? P_W'(w_trial) : P_W'(w_shift);
            r_dvd <= r_dvd << 1;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
               r_run  <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign o_done = r_done;
   assign o_rem  = r_rem;

endmodule

// File: rtl/gatebach_sieve_seg.sv
// Segmented sieve engine: loads a prime table, clears composites of one segment,
// streams the survivor bitmap word by word. Optional GATEBACH_SIEVE_STATS_EN adds
// a survivor counter output (prime_cnt).
module gatebach_sieve_seg
   import gatebach_sieve_pkg::*;
#(
   parameter int unsigned N_PRIMES  = DEF_N_PRIMES,
   parameter int unsigned WORD_W    = DEF_WORD_W,
   parameter int unsigned SEG_WORDS = DEF_SEG_WORDS,
   parameter int unsigned ADDR_W    = DEF_ADDR_W,
   parameter int unsigned P_W       = DEF_P_W
) (
   input  logic                              clk,
   input  logic                              i_rst_n,
   input  logic                              start,
   input  logic [ADDR_W-1:0]                 start_addr,
   input  logic [$clog2(N_PRIMES+1)-1:0]     n_primes,
   input  logic                              cs_in,
   input  logic [idx_w(N_PRIMES)-1:0]        add_in,
   input  logic [P_W-1:0]                    data_in,
   output logic                              busy,
   output logic                              proc_done,
   output logic                              store_done,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [idx_w(SEG_WORDS)-1:0]       out_idx,
   output logic [WORD_W-1:0]                 out_data
`ifdef GATEBACH_SIEVE_STATS_EN
   ,
   output logic [$clog2(SEG_WORDS*WORD_W+1)-1:0] prime_cnt
`endif
);

   localparam int unsigned SEG_BITS = SEG_WORDS * WORD_W;
   localparam int unsigned NP_W     = $clog2(N_PRIMES + 1);
   localparam int unsigned AD_W     = idx_w(N_PRIMES);
   localparam int unsigned IX_W     = idx_w(SEG_WORDS);
   localparam int unsigned BIT_W    = idx_w(SEG_BITS);

   state_t              r_state;
   logic                r_busy;
   logic                r_proc_done;
   logic                r_store_done;
   logic                r_out_valid;
   logic [IX_W-1:0]     r_out_idx;
   logic [WORD_W-1:0]   r_out_data;
   logic [SEG_BITS-1:0] r_bitmap;
   logic [ADDR_W-1:0]   r_start_addr;
   logic [NP_W-1:0]     r_n;
   logic [NP_W-1:0]     r_pidx;
   logic                r_div_first;
   logic [P_W-1:0]      r_p;
   logic [P_W:0]        r_off;
   logic [P_W-1:0]      r_tab [N_PRIMES];

   logic [P_W-1:0]      w_tab_p;
   logic [NP_W-1:0]     w_n_clamp;
   logic                w_last;
   logic                w_div_go;
   logic                w_div_done;
   logic [P_W-1:0]      w_rem;
   logic                w_in_seg;
   logic                w_is_self;
   logic                w_last_word;
   logic [IX_W-1:0]     w_nidx;
   logic [WORD_W-1:0]   w_words [SEG_WORDS];

   // Datapath decodes for the current prime, offset and output word.
   always_comb begin
      w_tab_p     = r_tab[AD_W'(r_pidx)];
      w_n_clamp   = (n_primes > NP_W'(N_PRIMES)) ? NP_W'(N_PRIMES) : n_primes;
      w_last      = (r_pidx + NP_W'(1)) == r_n;
      w_div_go    = (r_state == S_DIV) && r_div_first && (w_tab_p >= P_W'(2));
      w_in_seg    = r_off < (P_W+1)'(SEG_BITS);
      w_is_self   = ((ADDR_W+1)'(r_start_addr) + (ADDR_W+1)'(r_off)) == (ADDR_W+1)'(r_p);
      w_last_word = r_out_idx == IX_W'(SEG_WORDS - 1);
      w_nidx      = w_last_word ? '0 : r_out_idx + IX_W'(1);
      for (int k = 0; k < SEG_WORDS; k++) begin
         w_words[k] = r_bitmap[k*WORD_W +: WORD_W];
      end
   end

   gatebach_mod_div #(
      .ADDR_W (ADDR_W),
      .P_W    (P_W)
   ) u_div (
      .clk        (clk),
      .i_rst_n    (i_rst_n),
      .i_go       (w_div_go),
      .i_dividend (r_start_addr),
      .i_divisor  (w_tab_p),
      .o_done     (w_div_done),
      .o_rem      (w_rem)
   );

   // Prime table: host writes only while idle; contents survive reset.
   always_ff @(posedge clk) begin
      if (cs_in && (r_state == S_IDLE) && (32'(add_in) < N_PRIMES)) begin
         r_tab[add_in] <= data_in;
      end
   end

   // Control FSM plus bitmap marking and output streaming.
   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_busy       <= 1'b0;
         r_proc_done  <= 1'b0;
         r_store_done <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_idx    <= '0;
         r_out_data   <= '0;
         r_bitmap     <= '1;
         r_start_addr <= '0;
         r_n          <= '0;
         r_pidx       <= '0;
         r_div_first  <= 1'b0;
         r_p          <= '0;
         r_off        <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_start_addr <= start_addr;
                  r_n          <= w_n_clamp;
                  r_busy       <= 1'b1;
                  r_proc_done  <= 1'b0;
                  r_store_done <= 1'b0;
                  r_out_idx    <= '0;
                  r_pidx       <= '0;
                  if (w_n_clamp == '0) begin
                     r_bitmap    <= '1;
                     r_out_data  <= '1;
                     r_out_valid <= 1'b1;
                     r_proc_done <= 1'b1;
                     r_state     <= S_OUT;
                  end else begin
                     r_state <= S_INIT;
                  end
               end
            end
            S_INIT: begin
               r_bitmap    <= '1;
               r_pidx      <= '0;
               r_div_first <= 1'b1;
               r_state     <= S_DIV;
            end
            S_DIV: begin
               if (r_div_first) begin
                  r_div_first <= 1'b0;
                  // Primes below 2 mark nothing: move straight to the next entry.
                  if (w_tab_p < P_W'(2)) begin
                     r_pidx <= r_pidx + NP_W'(1);
                     if (w_last) begin
                        r_state     <= S_OUT;
                        r_out_valid <= 1'b1;
                        r_proc_done <= 1'b1;
                        r_out_idx   <= '0;
                        r_out_data  <= w_words[0];
                     end else begin
                        r_div_first <= 1'b1;
                     end
                  end
               end else if (w_div_done) begin
                  r_p     <= w_tab_p;
                  r_off   <= (w_rem == '0) ? '0 : (P_W+1)'(w_tab_p - w_rem);
                  r_state <= S_MARK;
               end
            end
            S_MARK: begin
               if (w_in_seg) begin
                  if (!w_is_self) begin
                     r_bitmap[r_off[BIT_W-1:0]] <= 1'b0;
                  end
                  r_off <= r_off + (P_W+1)'(r_p);
               end else begin
                  r_pidx <= r_pidx + NP_W'(1);
                  if (w_last) begin
                     r_state     <= S_OUT;
                     r_out_valid <= 1'b1;
                     r_proc_done <= 1'b1;
                     r_out_idx   <= '0;
                     r_out_data  <= w_words[0];
                  end else begin
                     r_div_first <= 1'b1;
                     r_state     <= S_DIV;
                  end
               end
            end
            S_OUT: begin
               // out_valid is always high here, so out_ready alone is the handshake.
               if (out_ready) begin
                  if (w_last_word) begin
                     r_out_valid  <= 1'b0;
                     r_store_done <= 1'b1;
                     r_state      <= S_DONE;
                  end else begin
                     r_out_idx  <= w_nidx;
                     r_out_data <= w_words[w_nidx];
                  end
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy       = r_busy;
   assign proc_done  = r_proc_done;
   assign store_done = r_store_done;
   assign out_valid  = r_out_valid;
   assign out_idx    = r_out_idx;
   assign out_data   = r_out_data;

`ifdef GATEBACH_SIEVE_STATS_EN
   localparam int unsigned CNT_W = $clog2(SEG_BITS + 1);

   logic [CNT_W-1:0] r_prime_cnt;
   logic [CNT_W-1:0] w_pop;

   // Survivor count of the word currently presented.
   always_comb begin
      w_pop = '0;
      for (int i = 0; i < WORD_W; i++) begin
         w_pop = w_pop + CNT_W'(r_out_data[i]);
      end
   end

   // Accumulate survivors over handshaken words; cleared on accepted start.
   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         r_prime_cnt <= '0;
      end else if ((r_state == S_IDLE) && start) begin
         r_prime_cnt <= '0;
      end else if ((r_state == S_OUT) && out_ready) begin
         r_prime_cnt <= r_prime_cnt + w_pop;
      end
   end

   assign prime_cnt = r_prime_cnt;
`endif

endmodule

// File: tb/tb_gatebach_sieve_seg.sv
// Self-checking bench for gatebach_sieve_seg (two-word segment build).
module tb_gatebach_sieve_seg;

   localparam int unsigned N_PRIMES  = 64;
   localparam int unsigned WORD_W    = 32;
   localparam int unsigned SEG_WORDS = 2;
   localparam int unsigned ADDR_W    = 64;
   localparam int unsigned P_W       = 32;
   localparam int unsigned SEG_BITS  = SEG_WORDS * WORD_W;
   localparam int unsigned MAX_CYC   = 20000;

   logic              clk = 1'b0;
   logic              i_rst_n;
   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic [6:0]        n_primes;
   logic              cs_in;
   logic [5:0]        add_in;
   logic [P_W-1:0]    data_in;
   logic              busy;
   logic              proc_done;
   logic              store_done;
   logic              out_valid;
   logic              out_ready;
   logic [0:0]        out_idx;
   logic [WORD_W-1:0] out_data;
`ifdef GATEBACH_SIEVE_STATS_EN
   logic [6:0]        prime_cnt;
`endif

   int          n_tests = 0;
   int          n_fail  = 0;
   int          exp_k   = 0;
   int          hs_cnt  = 0;
   logic [31:0] m_tab     [N_PRIMES];
   logic [31:0] exp_words [SEG_WORDS];
   logic [31:0] got_words [SEG_WORDS];
   int          exp_pop;

   gatebach_sieve_seg #(
      .N_PRIMES  (N_PRIMES),
      .WORD_W    (WORD_W),
      .SEG_WORDS (SEG_WORDS),
      .ADDR_W    (ADDR_W),
      .P_W       (P_W)
   ) dut (
      .clk        (clk),
      .i_rst_n    (i_rst_n),
      .start      (start),
      .start_addr (start_addr),
      .n_primes   (n_primes),
      .cs_in      (cs_in),
      .add_in     (add_in),
      .data_in    (data_in),
      .busy       (busy),
      .proc_done  (proc_done),
      .store_done (store_done),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_idx    (out_idx),
      .out_data   (out_data)
`ifdef GATEBACH_SIEVE_STATS_EN
      ,
      .prime_cnt  (prime_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Sieve rule stated directly on integers: survivors of the first n table primes.
   function automatic void model(input longint unsigned sa, input int n);
      logic [SEG_BITS-1:0] bm;
      longint unsigned p, r, off;
      int nn;
      nn = (n > int'(N_PRIMES)) ? int'(N_PRIMES) : n;
      bm = '1;
      for (int i = 0; i < nn; i++) begin
         p = longint'(m_tab[i]);
         if (p < 2) continue;
         r   = sa % p;
         off = (r == 0) ? 0 : p - r;
         for (longint unsigned m = off; m < SEG_BITS; m += p) begin
            if (sa + m != p) bm[m] = 1'b0;
         end
      end
      exp_pop = 0;
      for (int k = 0; k < int'(SEG_WORDS); k++) begin
         exp_words[k] = bm[k*WORD_W +: WORD_W];
         exp_pop += $countones(exp_words[k]);
      end
   endfunction

   // Every cycle with a valid word: index order, contents, and stability under stall.
   task automatic compare_loop();
      forever begin
         @(negedge clk);
         if (i_rst_n && out_valid) begin
            if (exp_k >= int'(SEG_WORDS)) begin
               n_tests++;
               n_fail++;
               $display("FAIL extra_word: idx %0d valid after %0d words", out_idx, exp_k);
            end else begin
               chk("out_idx", 64'(out_idx), 64'(exp_k));
               chk("out_data", 64'(out_data), 64'(exp_words[exp_k]));
               if (out_ready) begin
                  got_words[exp_k] = out_data;
                  exp_k++;
                  hs_cnt++;
               end
            end
         end
      end
   endtask

   task automatic load(input int idx, input logic [31:0] val);
      cs_in   = 1'b1;
      add_in  = 6'(idx);
      data_in = val;
      @(posedge clk); #1;
      cs_in   = 1'b0;
      m_tab[idx] = val;
   endtask

   task automatic run_seg(input string tag, input logic [63:0] sa, input int n,
                          input bit toggle, input int inj_start_at, input bit inj_cs);
      bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int cyc;
      bit did_cs;
      model(sa, n);
      exp_k  = 0;
      hs_cnt = 0;
      did_cs = 1'b0;
      got_words[0] = '0;
      got_words[1] = '0;
      start      = 1'b1;
      start_addr = sa;
      n_primes   = 7'(n);
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, "_busy_on_start"}, 64'(busy), 64'd1);
      chk({tag, "_store_done_cleared"}, 64'(store_done), 64'd0);
      cyc = 0;
      while (!store_done && cyc < int'(MAX_CYC)) begin
         out_ready = toggle ? pat[cyc % 4] : 1'b1;
         start     = (cyc == inj_start_at);
         if (inj_cs && out_valid && !did_cs) begin
            cs_in   = 1'b1;
            add_in  = 6'd0;
            data_in = 32'd11;
            did_cs  = 1'b1;
         end else begin
            cs_in = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      cs_in = 1'b0;
      chk({tag, "_store_done"}, 64'(store_done), 64'd1);
      chk({tag, "_handshakes"}, 64'(hs_cnt), 64'(SEG_WORDS));
      chk({tag, "_proc_done"}, 64'(proc_done), 64'd1);
      chk({tag, "_valid_low"}, 64'(out_valid), 64'd0);
`ifdef GATEBACH_SIEVE_STATS_EN
      chk({tag, "_prime_cnt"}, 64'(prime_cnt), 64'(exp_pop));
`endif
      @(posedge clk); #1;
      chk({tag, "_busy_off"}, 64'(busy), 64'd0);
      out_ready = 1'b1;
   endtask

   initial begin
      int cyc;
      fork
         compare_loop();
      join_none
      i_rst_n    = 1'b0;
      start      = 1'b0;
      start_addr = '0;
      n_primes   = '0;
      cs_in      = 1'b0;
      add_in     = '0;
      data_in    = '0;
      out_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_proc_done", 64'(proc_done), 64'd0);
      chk("rst_store_done", 64'(store_done), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_idx", 64'(out_idx), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      i_rst_n = 1'b1;
      @(posedge clk); #1;

      // Small primes from zero and from 100.
      load(0, 2); load(1, 3); load(2, 5); load(3, 7);
      run_seg("p4_a0", 64'd0, 4, 1'b0, -1, 1'b0);
      chk("p4_a0_model_w0", 64'(exp_words[0]), 64'hA08A28AE);
      chk("p4_a0_dut_w0", 64'(got_words[0]), 64'hA08A28AE);
      run_seg("p4_a100", 64'd100, 4, 1'b0, -1, 1'b0);
      chk("p4_a100_model_w0", 64'(exp_words[0]), 64'h8820228A);
      chk("p4_a100_dut_w0", 64'(got_words[0]), 64'h8820228A);

      // Two primes with a stalling consumer.
      run_seg("p2_stall", 64'd0, 2, 1'b1, -1, 1'b0);
      chk("p2_stall_dut_w0", 64'(got_words[0]), 64'hA28A28AE);

      // Entries 1 and 101: 1 is skipped, 101 only reaches offset 0 when start is 0.
      load(0, 1); load(1, 101);
      run_seg("p1_101_a1", 64'd1, 2, 1'b0, -1, 1'b0);
      chk("p1_101_a1_w0", 64'(got_words[0]), 64'hFFFFFFFF);
      chk("p1_101_a1_w1", 64'(got_words[1]), 64'hFFFFFFFF);
      run_seg("p1_101_a0", 64'd0, 2, 1'b0, -1, 1'b0);
      chk("p1_101_a0_w0", 64'(got_words[0]), 64'hFFFFFFFE);

      // No primes: all ones straight away.
      run_seg("n0", 64'd12345, 0, 1'b0, -1, 1'b0);
      chk("n0_w1", 64'(got_words[1]), 64'hFFFFFFFF);

      // Stray start mid-marking and table write during output are both ignored.
      load(0, 2); load(1, 3);
      run_seg("inject", 64'd0, 4, 1'b0, 70, 1'b1);
      run_seg("after_inject", 64'd0, 4, 1'b0, -1, 1'b0);
      chk("after_inject_w0", 64'(got_words[0]), 64'hA08A28AE);

      // Reset while streaming aborts to idle; a fresh run is unaffected.
      model(64'd0, 4);
      exp_k     = 0;
      out_ready = 1'b0;
      start     = 1'b1;
      start_addr = '0;
      n_primes  = 7'd4;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < int'(MAX_CYC)) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("abort_reached_out", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      i_rst_n   = 1'b0;
      out_ready = 1'b0;
      @(posedge clk); #1;
      i_rst_n = 1'b1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_proc_done", 64'(proc_done), 64'd0);
      chk("abort_store_done", 64'(store_done), 64'd0);
      out_ready = 1'b1;
      run_seg("post_abort", 64'd0, 4, 1'b0, -1, 1'b0);
      chk("post_abort_w0", 64'(got_words[0]), 64'hA08A28AE);

      // Full table with n_primes above the depth clamps to 64 entries.
      for (int i = 0; i < int'(N_PRIMES); i++) load(i, 32'(i));
      run_seg("clamp", 64'd0, 100, 1'b0, -1, 1'b0);
      run_seg("clamp_a64", 64'd64, 100, 1'b1, -1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
